// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory slave that holds each request
// for WAIT_CYCLES wait states before answering on a valid/ready channel.
module dmem_responder #(
    parameter int A_BITS      = 8,
    parameter int D_BITS      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [A_BITS-1:0] req_addr,
    input  logic [D_BITS-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [D_BITS-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (DEPTH < 1 || DEPTH > (1 << A_BITS)) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be in 1..2**A_BITS");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A_BITS:0] DEPTH_W = (A_BITS + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_W  = 4'(WAIT_CYCLES);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [A_BITS-1:0] addr_q;
    logic [D_BITS-1:0] wdata_q;
    logic              ready_q;
    logic              valid_q;
    logic [D_BITS-1:0] rdata_q;
    logic              err_q;

    logic [D_BITS-1:0] mem_q [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              commit;
    logic              acc_write;
    logic [A_BITS-1:0] acc_addr;
    logic [D_BITS-1:0] acc_wdata;
    logic              in_range;
    logic [IW-1:0]     acc_idx;
    logic [D_BITS-1:0] rdata_d;

    // With zero wait states the access happens on the acceptance edge,
    // so the live request is used instead of the latched copy.
    assign accept     = (state_q == IDLE) && req_valid;
    assign acc_write  = (state_q == IDLE) ? req_write : write_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
    assign enter_resp = ((state_q == WAIT) && (cnt_q == 4'd1))
                      || (accept && (WAIT_CYCLES == 0));
    assign in_range   = {1'b0, acc_addr} < DEPTH_W;
    assign acc_idx    = acc_addr[IW-1:0];
    assign commit     = enter_resp && acc_write && in_range && !rst;
    assign rdata_d    = !in_range ? '0
                      : acc_write ? acc_wdata
                      : mem_q[acc_idx];

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= WAIT_W;
                        ready_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: cnt_q <= cnt_q - 4'd1;
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                state_q <= RESP;
                valid_q <= 1'b1;
                rdata_q <= rdata_d;
                err_q   <= !in_range;
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default, DEPTH=128 and
// zero-wait-state instances driven from a vector table plus sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [7:0]  req_addr   [3];
    logic [15:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [15:0] resp_rdata [3];
    logic        resp_err   [3];
    logic        busy       [3];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1])
    );

    dmem_responder #(.WAIT_CYCLES(0)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]), .busy(busy[2])
    );

    typedef struct {
        int          k;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete transaction with resp_ready held high.
    task automatic xact(input int k, input bit wr, input logic [7:0] a,
                        input logic [15:0] d, output logic [15:0] rd,
                        output logic er);
        int n;
        @(negedge clk);
        req_valid[k]  = 1'b1;
        req_write[k]  = wr;
        req_addr[k]   = a;
        req_wdata[k]  = d;
        resp_ready[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        n = 0;
        while (!resp_valid[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("lat_k%0d_%02h", k, a), n, (k == 2) ? 0 : 2);
        rd = resp_rdata[k];
        er = resp_err[k];
        @(posedge clk);
        #1;
        chk($sformatf("idle_k%0d_%02h", k, a),
            {resp_valid[k], req_ready[k], busy[k]}, 3'b010);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt [15];
        logic [15:0] rd;
        logic        er;
        logic [15:0] res [2];
        int          nres;
        int          acc_at;
        int          n;
        int          nb;
        logic        rr;
        logic        rv;
        logic [15:0] rdv;

        vt[0]  = '{0, 1'b1, 8'h07, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{0, 1'b0, 8'h05, 16'h0000, 16'h1234, 1'b0};
        vt[2]  = '{0, 1'b1, 8'h06, 16'hBEEF, 16'hBEEF, 1'b0};
        vt[3]  = '{0, 1'b0, 8'h06, 16'h0000, 16'hBEEF, 1'b0};
        vt[4]  = '{0, 1'b1, 8'hFF, 16'h0F0F, 16'h0F0F, 1'b0};
        vt[5]  = '{0, 1'b0, 8'hFF, 16'h0000, 16'h0F0F, 1'b0};
        vt[6]  = '{1, 1'b1, 8'h10, 16'h0000, 16'h0000, 1'b0};
        vt[7]  = '{1, 1'b1, 8'h90, 16'h5555, 16'h0000, 1'b1};
        vt[8]  = '{1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0};
        vt[9]  = '{1, 1'b1, 8'h7F, 16'h7777, 16'h7777, 1'b0};
        vt[10] = '{1, 1'b0, 8'h80, 16'h0000, 16'h0000, 1'b1};
        vt[11] = '{1, 1'b0, 8'h7F, 16'h0000, 16'h7777, 1'b0};
        vt[12] = '{2, 1'b1, 8'h05, 16'h4321, 16'h4321, 1'b0};
        vt[13] = '{2, 1'b0, 8'h05, 16'h0000, 16'h4321, 1'b0};
        vt[14] = '{1, 1'b0, 8'h90, 16'h0000, 16'h0000, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = 8'h00;
            req_wdata[k]  = 16'h0000;
            resp_ready[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_k%0d", k),
                {req_ready[k], resp_valid[k], resp_rdata[k],
                 resp_err[k], busy[k]},
                {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;

        // Write timing with two wait states.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b1;
        req_addr[0]   = 8'h05;
        req_wdata[0]  = 16'h1234;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_ready_e%0d", i), req_ready[0], i == 3);
            chk($sformatf("t1_valid_e%0d", i), resp_valid[0], i == 2);
            if (i == 2) begin
                chk("t1_rdata", resp_rdata[0], 16'h1234);
                chk("t1_err", resp_err[0], 1'b0);
            end
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 15; i++) begin
            xact(vt[i].k, vt[i].wr, vt[i].addr, vt[i].wdata, rd, er);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("v%0d_err", i), er, vt[i].err);
        end

        // Back-to-back reads with req_valid held high.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_addr[0]   = 8'h05;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_addr[0] = 8'h06;
        nres = 0;
        acc_at = 0;
        res[0] = 16'h0000;
        res[1] = 16'h0000;
        for (int i = 1; i <= 10; i++) begin
            rr  = req_ready[0];
            rv  = resp_valid[0];
            rdv = resp_rdata[0];
            @(posedge clk);
            #1;
            if (rv && nres < 2) begin
                res[nres] = rdv;
                nres++;
            end
            if (rr && acc_at == 0) begin
                acc_at = i;
                req_valid[0] = 1'b0;
            end
        end
        chk("t2_accept_gap", acc_at, 4);
        chk("t2_resp0", res[0], 16'h1234);
        chk("t2_resp1", res[1], 16'hBEEF);

        // Backpressure: response held while resp_ready is low.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_addr[0]   = 8'h05;
        resp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!resp_valid[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_reach_resp", resp_valid[0], 1'b1);
        req_valid[0] = 1'b1;
        req_addr[0]  = 8'h06;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_hold_%0d", i),
                {resp_valid[0], req_ready[0], resp_rdata[0]},
                {1'b1, 1'b0, 16'h1234});
            @(posedge clk);
            #1;
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_release", {resp_valid[0], req_ready[0], busy[0]}, 3'b010);

        // Reset one cycle after accepting a write.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b1;
        req_addr[0]   = 8'h07;
        req_wdata[0]  = 16'hAAAA;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_busy_before", busy[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_async_reset",
            {req_ready[0], resp_valid[0], resp_rdata[0],
             resp_err[0], busy[0]},
            {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        xact(0, 1'b0, 8'h07, 16'h0000, rd, er);
        chk("t5_read_07", rd, 16'h0000);
        chk("t5_err_07", er, 1'b0);

        // Zero wait states: single-cycle busy.
        @(negedge clk);
        req_valid[2]  = 1'b1;
        req_write[2]  = 1'b0;
        req_addr[2]   = 8'h05;
        resp_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        chk("t6_valid_after_accept", resp_valid[2], 1'b1);
        chk("t6_rdata", resp_rdata[2], 16'h4321);
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy[2]) nb++;
            @(posedge clk);
            #1;
        end
        chk("t6_busy_cycles", nb, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
